spi_pdm_dac_mc: RTL and testbench



---
 rtl/spi_pdm_dac_mc.sv | 250 +++++++++++++++++++++++++
 tb/tb_spi_pdm_dac_mc.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_pdm_dac_mc.sv
// Multi-channel SPI-in / PDM-out audio path: generates serial_clk, deserialises
// NUM_CH signed words per cs-low frame and drives one sigma-delta bitstream per channel.
module spi_pdm_dac_mc #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned SCLK_DIV = 4,
    parameter int unsigned ORDER    = 1,
    parameter int unsigned PDM_DIV  = 1
) (
    input  logic                                           input_clk,
    input  logic                                           reset_n,
    input  logic                                           enable,
    input  logic                                           spi_mosi,
    input  logic                                           spi_cs,
    output logic                                           serial_clk,
    output logic [NUM_CH-1:0]                              dac_pdm_out,
    output logic                                           sample_valid,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] sample_ch,
    output logic [DATA_W-1:0]                              sample_data,
    output logic                                           frame_err,
    input  logic                                           err_clr
);

    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned IDX_W = $clog2(NUM_CH + 1);
    localparam int unsigned HALF  = SCLK_DIV / 2;
    localparam int unsigned DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned BIT_W = $clog2(DATA_W + 1);
    localparam int unsigned PD_W  = (PDM_DIV > 1) ? $clog2(PDM_DIV) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StLoad, StWait} state_t;

    logic [DIV_W-1:0]  div_q;
    logic              sclk_q;
    logic              sclk_tick;
    logic              sclk_rise;
    state_t            state_q, state_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  ch_idx_q, ch_idx_d;
    logic              drop_q, drop_d;
    logic              err_q;
    logic              set_err;
    logic              load_ok;
    logic [DATA_W-1:0] ch_reg_q [NUM_CH];
    logic [PD_W-1:0]   pd_q;
    logic              upd;

    assign sclk_tick = enable && (div_q == DIV_W'(HALF - 1));
    assign sclk_rise = sclk_tick && !sclk_q;

    always_ff @(posedge input_clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else if (!enable) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else if (sclk_tick) begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            div_q  <= div_q + DIV_W'(1);
        end
    end

    assign serial_clk = sclk_q;

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        ch_idx_d = ch_idx_q;
        drop_d   = drop_q;
        set_err  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sclk_rise) begin
                    ch_idx_d = '0;
                    if (!spi_cs) begin
                        shift_d = {shift_q[DATA_W-2:0], spi_mosi};
                        bit_d   = BIT_W'(1);
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                if (sclk_rise) begin
                    if (spi_cs) begin
                        set_err  = 1'b1;
                        ch_idx_d = '0;
                        drop_d   = 1'b0;
                        state_d  = StIdle;
                    end else begin
                        shift_d = {shift_q[DATA_W-2:0], spi_mosi};
                        bit_d   = bit_q + BIT_W'(1);
                        if (bit_q == BIT_W'(DATA_W - 1)) state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                state_d = StWait;
                // Only the first overflowing word of a frame raises the error.
                if (ch_idx_q == IDX_W'(NUM_CH)) begin
                    set_err = !drop_q;
                    drop_d  = 1'b1;
                end else begin
                    ch_idx_d = ch_idx_q + IDX_W'(1);
                end
            end
            StWait: begin
                if (sclk_rise) begin
                    if (spi_cs) begin
                        ch_idx_d = '0;
                        drop_d   = 1'b0;
                        state_d  = StIdle;
                    end else begin
                        shift_d = {shift_q[DATA_W-2:0], spi_mosi};
                        bit_d   = BIT_W'(1);
                        state_d = StShift;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (!enable) begin
            state_d  = StIdle;
            bit_d    = '0;
            ch_idx_d = '0;
            drop_d   = 1'b0;
            set_err  = 1'b0;
        end
    end

    assign load_ok = enable && (state_q == StLoad) && (ch_idx_q < IDX_W'(NUM_CH));

    always_ff @(posedge input_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            bit_q    <= '0;
            shift_q  <= '0;
            ch_idx_q <= '0;
            drop_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            ch_idx_q <= ch_idx_d;
            drop_q   <= drop_d;
            if (set_err)      err_q <= 1'b1;
            else if (err_clr) err_q <= 1'b0;
        end
    end

    always_ff @(posedge input_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) ch_reg_q[c] <= '0;
        end else if (load_ok) begin
            ch_reg_q[ch_idx_q[CH_W-1:0]] <= shift_q;
        end
    end

    assign sample_valid = load_ok;
    assign sample_ch    = ch_idx_q[CH_W-1:0];
    assign sample_data  = shift_q;
    assign frame_err    = err_q;

    assign upd = enable && (pd_q == PD_W'(PDM_DIV - 1));

    always_ff @(posedge input_clk or negedge reset_n) begin
        if (!reset_n)             pd_q <= '0;
        else if (!enable || upd)  pd_q <= '0;
        else                      pd_q <= pd_q + PD_W'(1);
    end

    if (ORDER == 2) begin : g_order2
        localparam int unsigned IW = DATA_W + 4;
        localparam int unsigned EW = IW + 2;
        localparam logic signed [EW-1:0] FS     = EW'(2 ** (DATA_W - 1));
        localparam logic signed [EW-1:0] CLAMP  = EW'(7 * 2 ** (DATA_W - 4));
        localparam logic signed [EW-1:0] SAT_HI = EW'(2 ** (IW - 1) - 1);
        localparam logic signed [EW-1:0] SAT_LO = ~SAT_HI;

        function automatic logic signed [IW-1:0] sat(input logic signed [EW-1:0] v);
            if (v > SAT_HI) return SAT_HI[IW-1:0];
            if (v < SAT_LO) return SAT_LO[IW-1:0];
            return v[IW-1:0];
        endfunction

        logic signed [IW-1:0] i1_q [NUM_CH];
        logic signed [IW-1:0] i2_q [NUM_CH];
        logic signed [IW-1:0] i1_n [NUM_CH];
        logic signed [IW-1:0] i2_n [NUM_CH];
        logic signed [EW-1:0] x;
        logic signed [EW-1:0] y;
        logic [NUM_CH-1:0]    out_q;

        always_comb begin
            x = '0;
            y = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                x = EW'($signed(ch_reg_q[c]));
                if (x > CLAMP)       x = CLAMP;
                else if (x < -CLAMP) x = -CLAMP;
                y = out_q[c] ? FS : -FS;
                i1_n[c] = sat(EW'(i1_q[c]) + x - y);
                i2_n[c] = sat(EW'(i2_q[c]) + EW'(i1_n[c]) - y);
            end
        end

        always_ff @(posedge input_clk or negedge reset_n) begin
            if (!reset_n || !enable) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    i1_q[c] <= '0;
                    i2_q[c] <= '0;
                end
                out_q <= '0;
            end else if (upd) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    i1_q[c]  <= i1_n[c];
                    i2_q[c]  <= i2_n[c];
                    out_q[c] <= ~i2_n[c][IW-1];
                end
            end
        end

        assign dac_pdm_out = out_q;
    end else begin : g_order1
        localparam logic [DATA_W-1:0] MSB = {1'b1, {(DATA_W - 1){1'b0}}};

        logic [DATA_W:0] acc_q [NUM_CH];

        // Carry out of the offset-binary accumulator is the bitstream.
        always_ff @(posedge input_clk or negedge reset_n) begin
            if (!reset_n || !enable) begin
                for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
            end else if (upd) begin
                for (int c = 0; c < NUM_CH; c++)
                    acc_q[c] <= {1'b0, acc_q[c][DATA_W-1:0]} + {1'b0, ch_reg_q[c] ^ MSB};
            end
        end

        always_comb begin
            dac_pdm_out = '0;
            for (int c = 0; c < NUM_CH; c++) dac_pdm_out[c] = acc_q[c][DATA_W];
        end
    end

endmodule

// File: tb/tb_spi_pdm_dac_mc.sv
// Directed bench for spi_pdm_dac_mc: one first-order and one second-order instance
// share the same SPI stream; framing, latency, densities and reset are checked.
module tb_spi_pdm_dac_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        mosi;
    logic        cs;
    logic        eclr;
    logic        sclk1, sclk2;
    logic [1:0]  pdm1, pdm2;
    logic        v1, v2;
    logic [0:0]  ch1, ch2;
    logic [15:0] d1, d2;
    logic        e1, e2;

    int checks = 0;
    int errors = 0;
    int vcount = 0;
    int vbefore;
    int a0, a1, b0, b1;

    always #5 clk = ~clk;

    spi_pdm_dac_mc #(.DATA_W(16), .NUM_CH(2), .SCLK_DIV(4), .ORDER(1), .PDM_DIV(1)) u_dut1 (
        .input_clk(clk), .reset_n(rst_n), .enable(en), .spi_mosi(mosi), .spi_cs(cs),
        .serial_clk(sclk1), .dac_pdm_out(pdm1), .sample_valid(v1), .sample_ch(ch1),
        .sample_data(d1), .frame_err(e1), .err_clr(eclr)
    );

    spi_pdm_dac_mc #(.DATA_W(16), .NUM_CH(2), .SCLK_DIV(4), .ORDER(2), .PDM_DIV(1)) u_dut2 (
        .input_clk(clk), .reset_n(rst_n), .enable(en), .spi_mosi(mosi), .spi_cs(cs),
        .serial_clk(sclk2), .dac_pdm_out(pdm2), .sample_valid(v2), .sample_ch(ch2),
        .sample_data(d2), .frame_err(e2), .err_clr(eclr)
    );

    always @(posedge clk) if (v1) vcount <= vcount + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic send_word(input logic [15:0] w, input logic exp_v, input logic exp_ch,
                             input string tag);
        @(negedge sclk1);
        cs   = 1'b0;
        mosi = w[15];
        for (int i = 14; i >= 0; i--) begin
            @(negedge sclk1);
            mosi = w[i];
        end
        @(posedge sclk1);
        #1;
        check({tag, "_valid"}, 32'(v1), 32'(exp_v));
        check({tag, "_valid2"}, 32'(v2), 32'(exp_v));
        check({tag, "_ch"}, 32'(ch1), 32'(exp_ch));
        check({tag, "_data"}, 32'(d1), 32'(w));
        #10;
        check({tag, "_valid_off"}, 32'(v1), 32'd0);
    endtask

    task automatic end_frame();
        @(negedge sclk1);
        cs = 1'b1;
        @(posedge sclk1);
        #1;
    endtask

    task automatic measure(input int n, output int c10, output int c11,
                           output int c20, output int c21);
        c10 = 0; c11 = 0; c20 = 0; c21 = 0;
        repeat (256) @(posedge clk);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            c10 += int'(pdm1[0]);
            c11 += int'(pdm1[1]);
            c20 += int'(pdm2[0]);
            c21 += int'(pdm2[1]);
        end
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 eclr = 1'b1;
        @(posedge clk);
        #1 eclr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; cs = 1'b1; mosi = 1'b0; eclr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sclk", 32'(sclk1), 32'd0);
        check("rst_pdm1", 32'(pdm1), 32'd0);
        check("rst_pdm2", 32'(pdm2), 32'd0);
        check("rst_valid", 32'(v1), 32'd0);
        check("rst_ch", 32'(ch1), 32'd0);
        check("rst_data", 32'(d1), 32'd0);
        check("rst_err", 32'(e1), 32'd0);
        rst_n = 1'b1;
        en    = 1'b1;

        // 0x0000 -> 50% ones
        send_word(16'h0000, 1'b1, 1'b0, "w0000");
        end_frame();
        measure(8192, a0, a1, b0, b1);
        check_rng("o1_0000", a0, 4088, 4104);
        check_rng("o2_0000", b0, 4055, 4137);

        // 0x7FFF -> at most one zero
        send_word(16'h7FFF, 1'b1, 1'b0, "w7fff");
        end_frame();
        measure(8192, a0, a1, b0, b1);
        check_rng("o1_7fff", a0, 8191, 8192);

        // 0x8000 -> constant 0 (order 1), clamped 6.25% (order 2)
        send_word(16'h8000, 1'b1, 1'b0, "w8000");
        end_frame();
        measure(8192, a0, a1, b0, b1);
        check("o1_8000", 32'(a0), 32'd0);
        check_rng("o2_8000", b0, 471, 553);

        // Two-word frame 0x4000, 0xC000
        vbefore = vcount;
        send_word(16'h4000, 1'b1, 1'b0, "f2w0");
        send_word(16'hC000, 1'b1, 1'b1, "f2w1");
        end_frame();
        check("f2_pulses", 32'(vcount - vbefore), 32'd2);
        measure(8192, a0, a1, b0, b1);
        check_rng("o1_4000", a0, 6136, 6152);
        check_rng("o1_c000", a1, 2040, 2056);
        check_rng("o2_4000", b0, 6103, 6185);
        check_rng("o2_c000", b1, 2007, 2089);

        // Short frame: cs high after 9 bits
        vbefore = vcount;
        @(negedge sclk1);
        cs = 1'b0; mosi = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge sclk1);
            mosi = i[0];
        end
        @(negedge sclk1);
        cs = 1'b1;
        @(posedge sclk1);
        #1;
        check("short_err", 32'(e1), 32'd1);
        check("short_novalid", 32'(vcount - vbefore), 32'd0);
        check("short_reg0", 32'(u_dut1.ch_reg_q[0]), 32'h4000);
        check("short_reg1", 32'(u_dut1.ch_reg_q[1]), 32'hC000);
        pulse_clr();
        check("short_clr", 32'(e1), 32'd0);
        send_word(16'h1111, 1'b1, 1'b0, "after_short");
        end_frame();
        check("after_reg0", 32'(u_dut1.ch_reg_q[0]), 32'h1111);

        // Overflow: three words into two channels
        vbefore = vcount;
        send_word(16'hAAAA, 1'b1, 1'b0, "ov0");
        send_word(16'h5555, 1'b1, 1'b1, "ov1");
        send_word(16'h0F0F, 1'b0, 1'b0, "ov2");
        end_frame();
        check("ov_pulses", 32'(vcount - vbefore), 32'd2);
        check("ov_err", 32'(e1), 32'd1);
        check("ov_err2", 32'(e2), 32'd1);
        check("ov_reg0", 32'(u_dut1.ch_reg_q[0]), 32'hAAAA);
        check("ov_reg1", 32'(u_dut1.ch_reg_q[1]), 32'h5555);

        // Disable: clock stops, outputs forced low, error and registers held
        @(posedge clk);
        #1 en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("dis_sclk", 32'(sclk1), 32'd0);
        check("dis_sclk2", 32'(sclk2), 32'd0);
        check("dis_pdm1", 32'(pdm1), 32'd0);
        check("dis_pdm2", 32'(pdm2), 32'd0);
        check("dis_err", 32'(e1), 32'd1);
        check("dis_reg0", 32'(u_dut1.ch_reg_q[0]), 32'hAAAA);
        en = 1'b1;
        pulse_clr();
        check("dis_clr", 32'(e1), 32'd0);

        // Reset at bit 7 of a word
        @(negedge sclk1);
        cs = 1'b0; mosi = 1'b1;
        for (int i = 0; i < 7; i++) @(negedge sclk1);
        @(posedge sclk1);
        #1;
        check("pre_rst_data", 32'(d1), 32'h0FFF);
        rst_n = 1'b0;
        #1;
        check("arst_data", 32'(d1), 32'd0);
        check("arst_sclk", 32'(sclk1), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("mrst_sclk", 32'(sclk1), 32'd0);
        check("mrst_pdm1", 32'(pdm1), 32'd0);
        check("mrst_pdm2", 32'(pdm2), 32'd0);
        check("mrst_valid", 32'(v1), 32'd0);
        check("mrst_err", 32'(e1), 32'd0);
        check("mrst_reg0", 32'(u_dut1.ch_reg_q[0]), 32'd0);
        cs    = 1'b1;
        mosi  = 1'b0;
        rst_n = 1'b1;
        send_word(16'h1234, 1'b1, 1'b0, "post_rst");
        end_frame();
        check("post_rst_reg0", 32'(u_dut1.ch_reg_q[0]), 32'h1234);
        check("post_rst_err", 32'(e1), 32'd0);
        check("post_rst_data2", 32'(d2), 32'h1234);
        check("post_rst_ch2", 32'(ch2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
